logic_unit_arbiter: RTL and testbench

//  Shares one logicBasic unit (AND/OR/XOR/NOT) between two requesters, e.g. execute and flag paths.

---
 rtl/logic_unit_arbiter_pkg.sv | 16 +
 rtl/logicBasic.sv | 26 ++
 rtl/logic_unit_arbiter.sv | 122 ++++++++++++
 tb/tb_logic_unit_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_arbiter_pkg.sv
// Shared opcodes and state encoding for the logic-unit arbiter.
// Imported by the arbiter top and its logicBasic datapath.
// Holds only types and constants, so no clocked behaviour lives here.
package logic_unit_arbiter_pkg;

    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOT = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } arbState_t;

endpackage

// File: rtl/logicBasic.sv
// Bitwise AND/OR/XOR/NOT on SIZE-bit operands; NOT uses x only.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module logicBasic
    import logic_unit_arbiter_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic [1:0]      code,
    output logic [SIZE-1:0] result
);

    always_comb begin
        result = '0;
        case (code)
            LOP_AND: result = x & y;
            LOP_OR:  result = x | y;
            LOP_XOR: result = x ^ y;
            LOP_NOT: result = ~x;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin share of one logicBasic unit between two requesters, registered result.
// Latency: result visible one cycle after the request handshake.
// Backpressure: both readies drop while the result slot is full and res_ready is low.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [SIZE-1:0]  req0_x,
    input  logic [SIZE-1:0]  req0_y,
    input  logic [1:0]       req0_code,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [SIZE-1:0]  req1_x,
    input  logic [SIZE-1:0]  req1_y,
    input  logic [1:0]       req1_code,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [SIZE-1:0]  res_data,
    output logic             res_id,
    output logic             res_zero,
    output logic [CNT_W-1:0] op_count
);

    arbState_t        state;
    arbState_t        stateNext;
    logic             lastGrant;
    logic             slotFree;
    logic             grant0;
    logic             grant1;
    logic             anyGrant;
    logic [SIZE-1:0]  selX;
    logic [SIZE-1:0]  selY;
    logic [1:0]       selCode;
    logic [SIZE-1:0]  opResult;
    logic [SIZE-1:0]  resData;
    logic             resId;
    logic             resZero;
    logic [CNT_W-1:0] opCount;

    // A draining result frees the slot in the same cycle, so refill can overlap drain.
    assign slotFree = (state == ST_IDLE) || res_ready;
    assign grant0   = slotFree && req0_valid && (!req1_valid || lastGrant);
    assign grant1   = slotFree && req1_valid && (!req0_valid || !lastGrant);
    assign anyGrant = grant0 || grant1;

    assign selX    = grant1 ? req1_x    : req0_x;
    assign selY    = grant1 ? req1_y    : req0_y;
    assign selCode = grant1 ? req1_code : req0_code;

    logicBasic #(.SIZE(SIZE)) uLogic (
        .x      (selX),
        .y      (selY),
        .code   (selCode),
        .result (opResult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: stateNext = anyGrant ? ST_FULL : ST_IDLE;
            ST_FULL: begin
                if (anyGrant) begin
                    stateNext = ST_FULL;
                end else if (res_ready) begin
                    stateNext = ST_IDLE;
                end else begin
                    stateNext = ST_FULL;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_comb begin
        res_valid  = (state == ST_FULL);
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // lastGrant resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resData   <= '0;
            resId     <= 1'b0;
            resZero   <= 1'b0;
            lastGrant <= 1'b1;
        end else if (anyGrant) begin
            resData   <= opResult;
            resId     <= grant1;
            resZero   <= (opResult == '0);
            lastGrant <= grant1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opCount <= '0;
        end else if (res_valid && res_ready) begin
            opCount <= opCount + 1'b1;
        end
    end

    assign res_data = resData;
    assign res_id   = resId;
    assign res_zero = resZero;
    assign op_count = opCount;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: directed issues push expected results,
// a negedge monitor pops and compares on every result handshake.
module tb_logic_unit_arbiter;
    import logic_unit_arbiter_pkg::*;

    localparam int SIZE  = 8;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [SIZE-1:0] data;
        logic            id;
        logic            zero;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [SIZE-1:0]  req0_x, req0_y, req1_x, req1_y;
    logic [1:0]       req0_code, req1_code;
    logic             res_valid, res_ready;
    logic [SIZE-1:0]  res_data;
    logic             res_id, res_zero;
    logic [CNT_W-1:0] op_count;

    exp_t expQ[$];
    exp_t monE;
    int   nVec = 0;
    int   nErr = 0;
    int   monCount = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_x     (req0_x),
        .req0_y     (req0_y),
        .req0_code  (req0_code),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_x     (req1_x),
        .req1_y     (req1_y),
        .req1_code  (req1_code),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_zero   (res_zero),
        .op_count   (op_count)
    );

    function automatic logic [SIZE-1:0] lop(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                                            input logic [1:0] code);
        case (code)
            LOP_AND: return x & y;
            LOP_OR:  return x | y;
            LOP_XOR: return x ^ y;
            default: return ~x;
        endcase
    endfunction

    function automatic exp_t mkExp(input logic id, input logic [SIZE-1:0] x,
                                   input logic [SIZE-1:0] y, input logic [1:0] code);
        exp_t e;
        e.data = lop(x, y, code);
        e.id   = id;
        e.zero = (e.data == '0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nVec++;
        if (act !== req) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
            monCount++;
            if (expQ.size() == 0) begin
                nVec++;
                nErr++;
                $display("FAIL spurious_result: got data=%h id=%b with no expected entry",
                         res_data, res_id);
            end else begin
                monE = expQ.pop_front();
                check("result", {22'd0, res_data, res_id, res_zero}, {22'd0, monE});
            end
        end
    end

    // Issue one op from a side; called at posedge+1, returns at posedge+1 after acceptance.
    task automatic issue(input logic side, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                         input logic [1:0] code);
        logic found;
        found = 1'b0;
        if (side) begin
            req1_valid = 1'b1; req1_x = x; req1_y = y; req1_code = code;
        end else begin
            req0_valid = 1'b1; req0_x = x; req0_y = y; req0_code = code;
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if ((side ? req1_ready : req0_ready) === 1'b1) begin
                expQ.push_back(mkExp(side, x, y, code));
                found = 1'b1;
                break;
            end
        end
        check("issue_accepted", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1;
        if (side) req1_valid = 1'b0; else req0_valid = 1'b0;
        if (found) check("result_latency", {31'd0, res_valid}, 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_x = '0; req0_y = '0; req0_code = '0;
        req1_x = '0; req1_y = '0; req1_code = '0;
        res_ready = 1'b0;
        #12;
        check("reset_res_valid", {31'd0, res_valid}, 32'd0);
        check("reset_res_fields", {22'd0, res_data, res_id, res_zero}, 32'd0);
        check("reset_op_count", {16'd0, op_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        #1;
        check("no_valid_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);

        // Single-requester directed ops
        issue(1'b0, 8'hF0, 8'h3C, LOP_AND);
        issue(1'b1, 8'hAA, 8'h55, LOP_AND);
        issue(1'b1, 8'hFF, 8'h00, LOP_NOT);
        issue(1'b0, 8'h0F, 8'hF0, LOP_OR);
        issue(1'b0, 8'h5A, 8'hFF, LOP_XOR);
        issue(1'b1, 8'h0C, 8'h0A, LOP_XOR);

        // Both valid continuously: last grant was 1, so order is 0,1,0,1,...
        req0_x = 8'h33; req0_y = 8'h0F; req0_code = LOP_OR;
        req1_x = 8'hC3; req1_y = 8'hFF; req1_code = LOP_AND;
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_ready", {30'd0, req0_ready, req1_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
            if (i % 2 == 0) expQ.push_back(mkExp(1'b0, 8'h33, 8'h0F, LOP_OR));
            else            expQ.push_back(mkExp(1'b1, 8'hC3, 8'hFF, LOP_AND));
            @(posedge clk);
            #1;
            check("fair_count", {16'd0, op_count}, monCount);
        end

        // Backpressure with both still valid; held result is requester 1's AND = C3
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
            check("stall_result", {22'd0, res_data, res_id, res_zero}, {22'd0, 8'hC3, 1'b1, 1'b0});
            @(posedge clk);
            #1;
            check("stall_count", {16'd0, op_count}, monCount);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("release_ready0", {30'd0, req0_ready, req1_ready}, 32'd2);
        expQ.push_back(mkExp(1'b0, 8'h33, 8'h0F, LOP_OR));
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(negedge clk);
        check("release_ready1", {30'd0, req0_ready, req1_ready}, 32'd1);
        expQ.push_back(mkExp(1'b1, 8'hC3, 8'hFF, LOP_AND));
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        check("drain_to_idle", {31'd0, res_valid}, 32'd0);
        check("idle_holds_data", {22'd0, res_data, res_id, res_zero}, {22'd0, 8'hC3, 1'b1, 1'b0});

        // Asynchronous reset while a result is stalled in the register
        res_ready = 1'b0;
        issue(1'b0, 8'hF0, 8'h0F, LOP_AND);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, res_valid}, 32'd0);
        check("async_rst_count", {16'd0, op_count}, 32'd0);
        expQ.delete();
        monCount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // Counter wrap: 65535 drains reach FFFF, one more wraps to 0
        req0_x = 8'hFF; req0_y = 8'h01; req0_code = LOP_AND;
        req0_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            check("bulk_ready", {31'd0, req0_ready}, 32'd1);
            expQ.push_back(mkExp(1'b0, 8'hFF, 8'h01, LOP_AND));
        end
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        check("count_all_ones", {16'd0, op_count}, 32'h0000FFFF);
        check("bulk_idle", {31'd0, res_valid}, 32'd0);
        issue(1'b1, 8'h00, 8'h00, LOP_XOR);
        @(posedge clk);
        #1;
        check("count_wrap", {16'd0, op_count}, 32'd0);

        for (int c = 0; c < 10 && expQ.size() != 0; c++) @(posedge clk);
        check("queue_drained", expQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
